// File: rtl/taus_urng_pkg.sv
// taus_pkg: shared constants and types for the taus88 uniform source.
// Holds the default seeds, the minimum legal seed per word, the FSM state
// enum and the seed-repair helper used when TAUS_SEED_FIX_EN is defined.
package taus_pkg;

    // Default seeds: index 0..2 = generator A s0..s2, 3..5 = generator B s0..s2.
    localparam logic [31:0] DEFAULT_SEED [6] = '{
        32'd12345, 32'd67890, 32'd13579,
        32'd24680, 32'd11223, 32'd44556
    };

    // Smallest seed per word (s0, s1, s2) that keeps its component non-degenerate.
    localparam logic [31:0] MIN_SEED [3] = '{32'd2, 32'd8, 32'd16};

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } taus_state_e;

    // Replace a seed word that is too small with its default.
    function automatic logic [31:0] seed_fix(input logic [31:0] value,
                                             input logic [31:0] min_value,
                                             input logic [31:0] dflt);
        seed_fix = (value < min_value) ? dflt : value;
    endfunction

endpackage

// File: rtl/taus_urng_if.sv
// taus_urng_if: sample stream from the uniform source to the Box-Muller stage.
interface taus_urng_if;
    logic [47:0] u0;
    logic [15:0] u1;
    logic        valid;
    logic        ready;

    modport master (output u0, output u1, output valid, input ready);
    modport slave  (input u0, input u1, input valid, output ready);
endinterface

// File: rtl/taus_urng_taus88_step.sv
// taus88_step: one combinational step of a three-component taus88 generator.
// Produces the updated states and the XOR of the updated states as output.
module taus88_step (
    input  logic [31:0] s0,
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    output logic [31:0] n0,
    output logic [31:0] n1,
    output logic [31:0] n2,
    output logic [31:0] y
);
    logic [31:0] b0_s;
    logic [31:0] b1_s;
    logic [31:0] b2_s;

    assign b0_s = ((s0 << 5'd13) ^ s0) >> 5'd19;
    assign n0   = ((s0 & 32'hFFFF_FFFE) << 5'd12) ^ b0_s;

    assign b1_s = ((s1 << 5'd2) ^ s1) >> 5'd25;
    assign n1   = ((s1 & 32'hFFFF_FFF8) << 5'd4) ^ b1_s;

    assign b2_s = ((s2 << 5'd3) ^ s2) >> 5'd11;
    assign n2   = ((s2 & 32'hFFFF_FFF0) << 5'd17) ^ b2_s;

    assign y = n0 ^ n1 ^ n2;
endmodule

// File: rtl/taus_urng.sv
// taus_urng: dual taus88 uniform source feeding the Box-Muller datapath.
// Generators A and B step together; u0 = {a, b[31:16]}, u1 = b[15:0].
// Optional macro TAUS_SEED_FIX_EN: repair too-small seed words at seed_load.
module taus_urng
    import taus_pkg::*;
#(
    parameter int unsigned WARMUP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_wr,
    input  logic [2:0]  seed_idx,
    input  logic [31:0] seed_data,
    input  logic        seed_load,
    output logic        busy,
    taus_urng_if.master smp
);
    localparam logic [15:0] WARM_CNT = 16'(WARMUP);
    // With no warm-up the first step after (re)start already produces a sample.
    localparam taus_state_e START_ST = (WARMUP == 0) ? ST_FILL : ST_WARM;

    logic [31:0] shadow_r   [6];
    logic [31:0] live_r     [6];
    logic [31:0] next_s     [6];
    logic [31:0] load_val_s [6];
    logic [31:0] a_out_s;
    logic [31:0] b_out_s;

    taus_state_e state_r;
    logic [15:0] cnt_r;
    logic [47:0] u0_r;
    logic [15:0] u1_r;
    logic        valid_r;
    logic        busy_r;

    taus88_step u_step_a (
        .s0(live_r[0]), .s1(live_r[1]), .s2(live_r[2]),
        .n0(next_s[0]), .n1(next_s[1]), .n2(next_s[2]), .y(a_out_s)
    );

    taus88_step u_step_b (
        .s0(live_r[3]), .s1(live_r[4]), .s2(live_r[5]),
        .n0(next_s[3]), .n1(next_s[4]), .n2(next_s[5]), .y(b_out_s)
    );

    // Shadow seed registers written through the register port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) shadow_r[i] <= DEFAULT_SEED[i];
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (seed_wr && (seed_idx == 3'(i))) shadow_r[i] <= seed_data;
            end
        end
    end

    // Values copied into the live state on seed_load (pre-write shadows).
    always_comb begin
        for (int i = 0; i < 6; i++) begin
`ifdef TAUS_SEED_FIX_EN
            load_val_s[i] = seed_fix(shadow_r[i], MIN_SEED[i % 3], DEFAULT_SEED[i]);
`else
            load_val_s[i] = shadow_r[i];
`endif
        end
    end

    // Warm-up / fill / run sequencing, live state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) live_r[i] <= DEFAULT_SEED[i];
            state_r <= START_ST;
            cnt_r   <= WARM_CNT;
            u0_r    <= 48'd0;
            u1_r    <= 16'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
        end else if (seed_load) begin
            // Stale u0/u1 are kept; only valid drops.
            for (int i = 0; i < 6; i++) live_r[i] <= load_val_s[i];
            state_r <= START_ST;
            cnt_r   <= WARM_CNT;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_WARM: begin
                    for (int i = 0; i < 6; i++) live_r[i] <= next_s[i];
                    cnt_r <= cnt_r - 16'd1;
                    if (cnt_r <= 16'd1) state_r <= ST_FILL;
                end
                ST_FILL: begin
                    for (int i = 0; i < 6; i++) live_r[i] <= next_s[i];
                    u0_r    <= {a_out_s, b_out_s[31:16]};
                    u1_r    <= b_out_s[15:0];
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (valid_r && smp.ready) begin
                        for (int i = 0; i < 6; i++) live_r[i] <= next_s[i];
                        u0_r <= {a_out_s, b_out_s[31:16]};
                        u1_r <= b_out_s[15:0];
                    end
                end
                default: begin
                    state_r <= START_ST;
                    cnt_r   <= WARM_CNT;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign smp.u0    = u0_r;
    assign smp.u1    = u1_r;
    assign smp.valid = valid_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_taus_urng.sv
// tb_taus_urng: self-checking bench for taus_urng.
// Two instances (WARMUP=16 and WARMUP=0) share all inputs. A stream-index
// reference model predicts, for each instance, when valid is high and which
// element of the taus88 output stream must be on u0/u1.
module tb_taus_urng;
    typedef logic [31:0] w32;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_wr;
    logic [2:0]  seed_idx;
    logic [31:0] seed_data;
    logic        seed_load;
    logic        ready_tb;
    logic        busy16;
    logic        busy0;

    taus_urng_if bus16 ();
    taus_urng_if bus0 ();
    assign bus16.ready = ready_tb;
    assign bus0.ready  = ready_tb;

    taus_urng #(.WARMUP(16)) dut16 (
        .clk(clk), .reset(reset), .seed_wr(seed_wr), .seed_idx(seed_idx),
        .seed_data(seed_data), .seed_load(seed_load), .busy(busy16), .smp(bus16)
    );

    taus_urng #(.WARMUP(0)) dut0 (
        .clk(clk), .reset(reset), .seed_wr(seed_wr), .seed_idx(seed_idx),
        .seed_data(seed_data), .seed_load(seed_load), .busy(busy0), .smp(bus0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference data written from the algorithm description.
    w32 DEF  [6] = '{32'd12345, 32'd67890, 32'd13579, 32'd24680, 32'd11223, 32'd44556};
    w32 MINV [3] = '{32'd2, 32'd8, 32'd16};
    int QSH  [3] = '{13, 2, 3};
    int RSH  [3] = '{19, 25, 11};
    int LSH  [3] = '{12, 4, 17};
    w32 MSK  [3] = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0};
    int WU   [2] = '{16, 0};

    w32 sh    [6];
    w32 ms    [2][6];
    w32 my    [2][2];
    int midx  [2] = '{0, 0};
    int since [2] = '{0, 0};
    int deliv [2] = '{0, 0};

    task automatic chk(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (inst %0d, t=%0t): got %h expected %h", name, d, $time, got, exp);
        end
    endtask

    function automatic w32 tw(input w32 s, input int k);
        return (((s << QSH[k]) ^ s) >> RSH[k]) ^ ((s & MSK[k]) << LSH[k]);
    endfunction

    task automatic m_step(input int d);
        for (int g = 0; g < 2; g++) begin
            w32 acc = 32'd0;
            for (int k = 0; k < 3; k++) begin
                ms[d][3*g+k] = tw(ms[d][3*g+k], k);
                acc = acc ^ ms[d][3*g+k];
            end
            my[d][g] = acc;
        end
        midx[d]++;
    endtask

    task automatic m_load(input int d);
        for (int i = 0; i < 6; i++) begin
`ifdef TAUS_SEED_FIX_EN
            ms[d][i] = (sh[i] < MINV[i%3]) ? DEF[i] : sh[i];
`else
            ms[d][i] = sh[i];
`endif
        end
        midx[d] = 0; since[d] = 0; deliv[d] = 0;
    endtask

    // n-th element (1-based) of the stream since the last (re)start.
    task automatic m_sample(input int d, input int n, output logic [47:0] e0,
                            output logic [15:0] e1);
        while (midx[d] < n) m_step(d);
        e0 = {my[d][0], my[d][1][31:16]};
        e1 = my[d][1][15:0];
    endtask

    task automatic tick();
        bit xf [2];
        logic [47:0] e0;
        logic [15:0] e1;
        logic        v;
        logic        b;
        logic [47:0] g0;
        logic [15:0] g1;
        for (int d = 0; d < 2; d++) xf[d] = (since[d] >= WU[d] + 1) && (ready_tb == 1'b1);
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 6; i++) sh[i] = DEF[i];
            for (int d = 0; d < 2; d++) m_load(d);
        end else begin
            if (seed_load) begin
                for (int d = 0; d < 2; d++) m_load(d);
            end else begin
                for (int d = 0; d < 2; d++) begin
                    since[d]++;
                    if (xf[d]) deliv[d]++;
                end
            end
            if (seed_wr && seed_idx < 3'd6) sh[seed_idx] = seed_data;
        end
        for (int d = 0; d < 2; d++) begin
            v  = (d == 0) ? bus16.valid : bus0.valid;
            b  = (d == 0) ? busy16 : busy0;
            g0 = (d == 0) ? bus16.u0 : bus0.u0;
            g1 = (d == 0) ? bus16.u1 : bus0.u1;
            chk("valid", d, 64'(v), 64'(since[d] >= WU[d] + 1));
            chk("busy", d, 64'(b), 64'(since[d] < WU[d] + 1));
            if (reset) begin
                chk("u0_reset", d, 64'(g0), 64'd0);
                chk("u1_reset", d, 64'(g1), 64'd0);
            end else if (since[d] >= WU[d] + 1) begin
                m_sample(d, WU[d] + 1 + deliv[d], e0, e1);
                chk("u0", d, 64'(g0), 64'(e0));
                chk("u1", d, 64'(g1), 64'(e1));
            end
        end
    endtask

    task automatic idle();
        seed_wr = 1'b0; seed_load = 1'b0; seed_idx = 3'd0; seed_data = 32'd0;
    endtask

    task automatic write_seeds(input logic [5:0][31:0] s);
        for (int i = 0; i < 6; i++) begin
            seed_wr = 1'b1; seed_idx = 3'(i); seed_data = s[i];
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic [5:0][31:0] seed;
        logic [47:0]      e0;
        logic [15:0]      e1;
    } ks_t;

    ks_t ks [3];

    initial begin
        ks[0].seed = {32'd16, 32'd8, 32'd2, 32'd16, 32'd8, 32'd2};
        ks[0].e0 = 48'h002020800020; ks[0].e1 = 16'h2080;
        ks[1].seed = {32'd16, 32'd8, 32'd2, 32'd32, 32'd16, 32'd4};
        ks[1].e0 = 48'h004041000020; ks[1].e1 = 16'h2080;
        ks[2].seed = {32'd32, 32'd16, 32'd4, 32'd16, 32'd8, 32'd2};
        ks[2].e0 = 48'h002020800040; ks[2].e1 = 16'h4100;

        idle();
        ready_tb = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset latency and free-running stream.
        repeat (40) tick();

        // Random backpressure.
        for (int i = 0; i < 200; i++) begin
            ready_tb = 1'($urandom_range(0, 1));
            tick();
        end

        // Hold ready low for five cycles with valid high.
        ready_tb = 1'b1;
        tick();
        ready_tb = 1'b0;
        repeat (5) tick();
        ready_tb = 1'b1;
        repeat (5) tick();

        // Known seeds, each loaded mid-stream with ready high.
        for (int t = 0; t < 3; t++) begin
            write_seeds(ks[t].seed);
            seed_load = 1'b1;
            tick();
            idle();
            tick();
            chk("known_u0", 1, 64'(bus0.u0), 64'(ks[t].e0));
            chk("known_u1", 1, 64'(bus0.u1), 64'(ks[t].e1));
            repeat (20) tick();
        end

        // Write and load together: the load sees the old shadow value.
        seed_wr = 1'b1; seed_idx = 3'd0; seed_data = 32'd5; seed_load = 1'b1;
        tick();
        idle();
        tick();
        chk("wr_load_old", 1, 64'(bus0.u0), 64'h002020800040);
        repeat (20) tick();
        seed_load = 1'b1;
        tick();
        idle();
        tick();
        chk("wr_load_new", 1, 64'(bus0.u0), 64'h002040800040);
        repeat (20) tick();

        // All-zero seeds.
        write_seeds('0);
        seed_load = 1'b1;
        tick();
        idle();
        repeat (30) tick();

        // Random seed traffic, loads and backpressure.
        for (int i = 0; i < 400; i++) begin
            seed_wr   = 1'($urandom_range(0, 3) == 0);
            seed_idx  = 3'($urandom_range(0, 7));
            seed_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            seed_load = 1'($urandom_range(0, 29) == 0);
            ready_tb  = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        ready_tb = 1'b1;
        repeat (20) tick();

        // Reset overrides a simultaneous write and load.
        reset = 1'b1; seed_wr = 1'b1; seed_idx = 3'd1; seed_data = 32'd0; seed_load = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        repeat (30) tick();
        seed_load = 1'b1;
        tick();
        idle();
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
